// File: rtl/alu_opb_stage.sv
// Operand-B selector with rs2 forwarding, feeding a one-entry ready/valid
// register between decode and execute. Flags out-of-range selects stickily.
module alu_opb_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter int RA_W    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_SRC*XLEN-1:0] src_bus,
    input  logic [RA_W-1:0]         rs2_addr,
    input  logic                    ex_fwd_we,
    input  logic [RA_W-1:0]         ex_fwd_addr,
    input  logic [XLEN-1:0]         ex_fwd_data,
    input  logic                    wb_fwd_we,
    input  logic [RA_W-1:0]         wb_fwd_addr,
    input  logic [XLEN-1:0]         wb_fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         op_b,
    output logic [1:0]              op_b_src,
    output logic                    sel_err
);

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_EX   = 2'b01;
    localparam logic [1:0] TAG_WB   = 2'b10;
    localparam logic [1:0] TAG_ILL  = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [1:0]      tag;
    } opb_t;

    logic [NUM_SRC-1:0][XLEN-1:0] srcs;
    opb_t nxt, held;
    logic vld, illegal, ex_hit, wb_hit, accept;

    assign srcs = src_bus;

    // x0 is hardwired zero, so a write to it must never be forwarded
    assign ex_hit = ex_fwd_we && (ex_fwd_addr == rs2_addr) && (rs2_addr != '0);
    assign wb_hit = wb_fwd_we && (wb_fwd_addr == rs2_addr) && (rs2_addr != '0);

    always_comb begin
        nxt     = '0;
        illegal = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                illegal  = 1'b0;
                nxt.data = srcs[i];
            end
        end
        if (illegal) begin
            nxt.tag = TAG_ILL;
        end else if (sel == '0) begin
            if (ex_hit) begin
                nxt.data = ex_fwd_data;
                nxt.tag  = TAG_EX;
            end else if (wb_hit) begin
                nxt.data = wb_fwd_data;
                nxt.tag  = TAG_WB;
            end else begin
                nxt.tag  = TAG_NONE;
            end
        end
    end

    assign in_ready = !vld || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld     <= 1'b0;
            held    <= '0;
            sel_err <= 1'b0;
        end else if (flush) begin
            vld <= 1'b0;
        end else if (accept) begin
            vld  <= 1'b1;
            held <= nxt;
            if (illegal)
                sel_err <= 1'b1;
        end else if (vld && out_ready) begin
            vld <= 1'b0;
        end
    end

    assign out_valid = vld;
    assign op_b      = held.data;
    assign op_b_src  = held.tag;

endmodule

// File: tb/tb_alu_opb_stage.sv
// Bench for alu_opb_stage: a 4-source and a 3-source instance share stimulus;
// a behavioural model is compared every cycle, plus directed literal checks.
module tb_alu_opb_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [1:0]  sel;
    logic [31:0] src [4];
    logic [4:0]  rs2_addr, ex_addr, wb_addr;
    logic        ex_we, wb_we;
    logic [31:0] ex_data, wb_data;
    logic [127:0] bus4;
    logic [95:0]  bus3;

    logic        ov4, ir4, e4, ov3, ir3, e3;
    logic [31:0] b4, b3;
    logic [1:0]  t4, t3;

    int checks = 0;
    int errors = 0;
    bit en = 1'b0;

    always #5 clk = ~clk;

    assign bus4 = {src[3], src[2], src[1], src[0]};
    assign bus3 = {src[2], src[1], src[0]};

    alu_opb_stage #(.XLEN(32), .NUM_SRC(4), .RA_W(5)) dut4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir4),
        .sel(sel), .src_bus(bus4), .rs2_addr(rs2_addr),
        .ex_fwd_we(ex_we), .ex_fwd_addr(ex_addr), .ex_fwd_data(ex_data),
        .wb_fwd_we(wb_we), .wb_fwd_addr(wb_addr), .wb_fwd_data(wb_data),
        .out_valid(ov4), .out_ready(out_ready), .op_b(b4), .op_b_src(t4), .sel_err(e4)
    );

    alu_opb_stage #(.XLEN(32), .NUM_SRC(3), .RA_W(5)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir3),
        .sel(sel), .src_bus(bus3), .rs2_addr(rs2_addr),
        .ex_fwd_we(ex_we), .ex_fwd_addr(ex_addr), .ex_fwd_data(ex_data),
        .wb_fwd_we(wb_we), .wb_fwd_addr(wb_addr), .wb_fwd_data(wb_data),
        .out_valid(ov3), .out_ready(out_ready), .op_b(b3), .op_b_src(t3), .sel_err(e3)
    );

    // Model: what operand and tag the rules demand for the current inputs
    function automatic logic [33:0] pick(int ns);
        if (int'(sel) >= ns) return {2'b11, 32'h0};
        if (sel != 2'd0) return {2'b00, src[sel]};
        if (rs2_addr != 5'd0 && ex_we && ex_addr == rs2_addr) return {2'b01, ex_data};
        if (rs2_addr != 5'd0 && wb_we && wb_addr == rs2_addr) return {2'b10, wb_data};
        return {2'b00, src[0]};
    endfunction

    logic        mv [2];
    logic [31:0] mb [2];
    logic [1:0]  mt [2];
    logic        me [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [33:0] r;
            r = pick(k == 0 ? 4 : 3);
            if (rst) begin
                mv[k] = 1'b0; mb[k] = '0; mt[k] = '0; me[k] = 1'b0;
            end else if (flush) begin
                mv[k] = 1'b0;
            end else if (in_valid && (!mv[k] || out_ready)) begin
                mv[k] = 1'b1; mb[k] = r[31:0]; mt[k] = r[33:32];
                if (r[33:32] == 2'b11) me[k] = 1'b1;
            end else if (out_ready) begin
                mv[k] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_dut(input int k, input logic v, input logic ir, input logic [31:0] b,
                           input logic [1:0] t, input logic e);
        string p;
        p = (k == 0) ? "n4" : "n3";
        chk({p, ".out_valid"}, 64'(v), 64'(mv[k]));
        chk({p, ".in_ready"}, 64'(ir), 64'(!mv[k] || out_ready));
        chk({p, ".sel_err"}, 64'(e), 64'(me[k]));
        if (mv[k]) begin
            chk({p, ".op_b"}, 64'(b), 64'(mb[k]));
            chk({p, ".op_b_src"}, 64'(t), 64'(mt[k]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (en) begin
            chk_dut(0, ov4, ir4, b4, t4, e4);
            chk_dut(1, ov3, ir3, b3, t3, e3);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0;
        src[0] = 32'h11; src[1] = 32'h123; src[2] = 32'h222; src[3] = 32'h333;
        rs2_addr = 5'd0; ex_we = 1'b0; ex_addr = 5'd0; ex_data = 32'h0;
        wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
        tick(); tick();
        rst = 1'b0; en = 1'b1;
        chk("reset.out_valid", 64'(ov4), 64'(0));
        chk("reset.in_ready", 64'(ir4), 64'(1));
        chk("reset.op_b", 64'(b4), 64'(0));
        chk("reset.op_b_src", 64'(t4), 64'(0));
        chk("reset.sel_err", 64'({e4, e3}), 64'(0));

        // single transfer, then four back-to-back with sel 0..3
        in_valid = 1'b1; sel = 2'd1;
        tick();
        chk("t1.valid", 64'(ov4), 64'(1));
        chk("t1.op_b", 64'(b4), 64'h123);
        chk("t1.tag", 64'(t4), 64'(0));
        sel = 2'd0; tick(); chk("bb0.op_b", 64'({ov4, b4}), {31'd0, 1'b1, 32'h11});
        sel = 2'd1; tick(); chk("bb1.op_b", 64'({ov4, b4}), {31'd0, 1'b1, 32'h123});
        sel = 2'd2; tick(); chk("bb2.op_b", 64'({ov4, b4}), {31'd0, 1'b1, 32'h222});
        sel = 2'd3; tick(); chk("bb3.op_b", 64'({ov4, b4}), {31'd0, 1'b1, 32'h333});
        chk("ill.n3", 64'({ov3, b3, t3, e3}), {28'd0, 1'b1, 32'h0, 2'b11, 1'b1});
        chk("ill.n4_err", 64'(e4), 64'(0));

        // forwarding priority and x0 suppression
        sel = 2'd0; rs2_addr = 5'd5;
        ex_we = 1'b1; ex_addr = 5'd5; ex_data = 32'hAA;
        wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hBB;
        tick(); chk("fwd.ex", 64'({b4, t4}), {30'd0, 32'hAA, 2'b01});
        ex_we = 1'b0;
        tick(); chk("fwd.wb", 64'({b4, t4}), {30'd0, 32'hBB, 2'b10});
        ex_we = 1'b1; rs2_addr = 5'd0; ex_addr = 5'd0; wb_addr = 5'd0;
        tick(); chk("fwd.x0", 64'({b4, t4}), {30'd0, 32'h11, 2'b00});
        chk("fwd.x0.n3", 64'(e3), 64'(1));

        // stall holds the operand while inputs move
        sel = 2'd2; src[2] = 32'h55;
        tick(); chk("st.load", 64'(b4), 64'h55);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i); src[0] = 32'h900 + 32'(i); rs2_addr = 5'd7;
            ex_addr = 5'd7; ex_data = 32'hE0 + 32'(i);
            tick();
            chk("st.hold", 64'({ov4, ir4, b4, t4}), {29'd0, 1'b1, 1'b0, 32'h55, 2'b00});
        end
        sel = 2'd1; out_ready = 1'b1;
        #1; chk("st.ready", 64'(ir4), 64'(1));
        tick(); chk("st.swap", 64'({ov4, b4}), {31'd0, 1'b1, 32'h123});

        // flush while valid with a new input pending
        flush = 1'b1; in_valid = 1'b1; sel = 2'd3;
        tick();
        chk("fl.valid", 64'({ov4, ov3}), 64'(0));
        chk("fl.err", 64'({e4, e3}), 64'(1));
        flush = 1'b0; in_valid = 1'b0;
        tick(); chk("fl.drop", 64'(ov4), 64'(0));

        // reset during a stall
        in_valid = 1'b1; sel = 2'd2;
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        tick(); chk("rs.stalled", 64'({ov4, ir4}), 64'(2));
        rst = 1'b1;
        tick();
        chk("rs.clear", 64'({ov4, ir4, b4, t4, e4, e3}), {26'd0, 1'b0, 1'b1, 32'h0, 2'b00, 2'b00});
        rst = 1'b0; out_ready = 1'b1;
        tick(); tick();
        en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
